// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes into start/data/stop frames on dcom, paced by an oversampling tick
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick_in,
  input  logic [DATA_BITS-1:0] i_data_in,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  output logic                 o_dcom,
  output logic                 o_busy,
  output logic                 o_tx_done
);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS) + 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] DATA_LAST = BIW'(DATA_BITS - 1);
  localparam logic [BIW-1:0] STOP_LAST = BIW'(STOP_BITS - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t               r_state, w_state;
  logic [TCW-1:0]       r_tick_cnt, w_tick_cnt;
  logic [BIW-1:0]       r_bit_idx, w_bit_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_dcom, w_dcom;
  logic                 r_busy, w_busy;
  logic                 r_ready, w_ready;
  logic                 r_done, w_done;
  logic                 w_bit_end;
  // state and registered outputs; reset aborts any partial frame and idles the line high
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_dcom     <= 1'b1;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick_cnt <= w_tick_cnt;
      r_bit_idx  <= w_bit_idx;
      r_shift    <= w_shift;
      r_dcom     <= w_dcom;
      r_busy     <= w_busy;
      r_ready    <= w_ready;
      r_done     <= w_done;
    end
  end
  // next state: ticks are counted only inside a frame; a bit ends on the OVERSAMPLE-th tick
  always_comb begin
    w_state    = r_state;
    w_tick_cnt = r_tick_cnt;
    w_bit_idx  = r_bit_idx;
    w_shift    = r_shift;
    w_dcom     = r_dcom;
    w_busy     = r_busy;
    w_ready    = r_ready;
    w_done     = 1'b0;
    w_bit_end  = (r_state != S_IDLE) && i_tick_in && (r_tick_cnt == TICK_LAST);
    if (r_state != S_IDLE && i_tick_in) w_tick_cnt = w_bit_end ? '0 : r_tick_cnt + 1'b1;
    case (r_state)
      S_IDLE: if (i_data_valid) begin
        w_state    = S_START;
        w_shift    = i_data_in;
        w_tick_cnt = '0;
        w_bit_idx  = '0;
        w_dcom     = 1'b0;
        w_busy     = 1'b1;
        w_ready    = 1'b0;
      end
      S_START: if (w_bit_end) begin
        w_state = S_DATA;
        w_dcom  = r_shift[0];
      end
      S_DATA: if (w_bit_end) begin
        w_shift = r_shift >> 1;
        if (r_bit_idx == DATA_LAST) begin
          w_state   = S_STOP;
          w_bit_idx = '0;
          w_dcom    = 1'b1;
        end else begin
          w_bit_idx = r_bit_idx + 1'b1;
          w_dcom    = r_shift[1];
        end
      end
      S_STOP: if (w_bit_end) begin
        if (r_bit_idx == STOP_LAST) begin
          w_state   = S_IDLE;
          w_bit_idx = '0;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_ready   = 1'b1;
        end else begin
          w_bit_idx = r_bit_idx + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  assign o_data_ready = r_ready;
  assign o_dcom       = r_dcom;
  assign o_busy       = r_busy;
  assign o_tx_done    = r_done;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: random and directed frames checked cycle by cycle against a tick-count line model
module tb_uart_transmitter;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int BOUND = 20000;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       chk_en = 1'b0;
  logic       tick_en = 1'b1;
  int         tick_div = 1;
  int         tcnt = 0;
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // tick source: one pulse every tick_div clocks while enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (tick_en) begin
      tcnt++;
      tick_in = (tcnt % tick_div) == 0;
    end else tick_in = 1'b0;
  end
  // one DUT per stop-bit setting, each with its own model: expected line is the frame bit
  // selected by (ticks since accept) / OS, and the frame ends after (1+DB+SB)*OS ticks
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int SB = g + 1;
    localparam int NB = 1 + DB + SB;
    logic       dcom, busy, ready, done;
    logic       m_act = 1'b0;
    logic       m_done = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_frame = 8'h00;
    int         k;
    logic       m_line;
    uart_transmitter #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick_in(tick_in), .i_data_in(data_in),
      .i_data_valid(data_valid), .o_data_ready(ready), .o_dcom(dcom), .o_busy(busy),
      .o_tx_done(done)
    );
    always @(posedge clk) begin
      m_done <= 1'b0;
      if (!rst_n) begin
        m_act   <= 1'b0;
        m_ticks <= 0;
      end else if (!m_act) begin
        if (data_valid) begin
          m_act   <= 1'b1;
          m_ticks <= 0;
          m_frame <= data_in;
        end
      end else if (tick_in) begin
        if (m_ticks + 1 == NB * OS) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end else m_ticks <= m_ticks + 1;
      end
    end
    always @(negedge clk) begin
      k = m_ticks / OS;
      m_line = !m_act ? 1'b1 : (k == 0) ? 1'b0 : (k <= DB) ? m_frame[k-1] : 1'b1;
      if (chk_en) begin
        check($sformatf("sb%0d_dcom", SB), 32'(dcom), 32'(m_line));
        check($sformatf("sb%0d_busy", SB), 32'(busy), 32'(m_act));
        check($sformatf("sb%0d_ready", SB), 32'(ready), 32'(!m_act));
        check($sformatf("sb%0d_tx_done", SB), 32'(done), 32'(m_done));
      end
    end
  end
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    data_in = b;
    data_valid = 1'b1;
    for (n = 0; n < BOUND && !cfg[0].ready; n++) @(negedge clk);
    if (n == BOUND) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    for (n = 0; n < BOUND && (cfg[0].busy || cfg[1].busy); n++) @(negedge clk);
    if (n == BOUND) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask
  task automatic wait_clks(input int c);
    repeat (c) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h3C;
    @(posedge clk);
    chk_en = 1'b1;
    wait_clks(3);
    data_valid = 1'b0;
    rst_n = 1'b1;
    wait_clks(20);
    send(8'hA5);
    wait_idle();
    send(8'h00);
    send(8'hFF);
    wait_idle();
    tick_div = 2;
    send(8'hC3);
    wait_clks(3 * OS * tick_div);
    data_in = 8'h11;
    data_valid = 1'b1;
    wait_clks(1);
    data_valid = 1'b0;
    wait_idle();
    send(8'h96);
    wait_clks(4 * OS * tick_div + OS);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(5);
    send(8'h5A);
    wait_idle();
    tick_div = 1;
    send(8'h6E);
    wait_clks(10 * OS + 7);
    tick_en = 1'b0;
    wait_clks(100);
    tick_en = 1'b1;
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      tick_div = 1 + int'($urandom_range(0, 2));
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        wait_clks(int'($urandom_range(5, 10 * OS * tick_div)));
        data_in = 8'($urandom);
        data_valid = 1'b1;
        wait_clks(1);
        data_valid = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        wait_clks(int'($urandom_range(1, 8 * OS * tick_div)));
        rst_n = 1'b0;
        wait_clks(1);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    wait_clks(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
